product_accumulator: RTL and testbench

- Downstream consumer of the registered multiplier output (A*B, width 2*bw). It sums a run of NTERMS unsigned products into a guard-extended accumulator.
- It presents the finished sum through a valid/ready handshake and asserts backpressure on the product stream while a result is pending.
- Forms the accumulate half of the dot-product / MAC datapath.

---
 rtl/product_accumulator.sv | 76 +++++++
 tb/tb_product_accumulator.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: sums runs of NTERMS unsigned products and hands each total off over valid/ready.
module product_accumulator #(
    parameter int bw     = 64,
    parameter int GUARD  = 4,
    parameter int NTERMS = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [2*bw:1]         P,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic                  clear,
    output logic [2*bw+GUARD:1]   SUM,
    output logic                  sum_valid,
    input  logic                  sum_ready,
    output logic [7:0]            count,
    output logic                  overflow
);
    localparam int SW = 2*bw+GUARD;
    typedef enum logic {ACC, HOLD} state_t;
    state_t state, state_n;
    logic [SW-1:0] acc, acc_n, sum_n;
    logic [SW:0] add;
    logic [7:0] cnt_n;
    logic ovf_n, accept;
    assign in_ready  = (state == ACC);
    assign sum_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    // extra top bit of the sum is the carry out of the accumulator MSB
    assign add = {1'b0, acc} + {{(GUARD+1){1'b0}}, P};
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= ACC;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            SUM      <= '0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            count    <= cnt_n;
            overflow <= ovf_n;
            SUM      <= sum_n;
        end
    end
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = count;
        ovf_n   = overflow;
        sum_n   = SUM;
        if (clear) begin
            state_n = ACC;
            acc_n   = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
        end else if (state == ACC) begin
            if (accept) begin
                acc_n = add[SW-1:0];
                cnt_n = count + 8'd1;
                ovf_n = overflow | add[SW];
            end
            // a flush only closes a run that holds at least one term
            if ((accept && cnt_n == 8'(NTERMS)) || (flush && cnt_n != 8'd0)) begin
                state_n = HOLD;
                sum_n   = acc_n;
            end
        end else if (sum_ready) begin
            state_n = ACC;
            acc_n   = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: scoreboard bench for two parameterisations of product_accumulator.
module tb_product_accumulator;
    typedef struct {
        logic [131:0] sum;
        logic [7:0]   cnt;
        logic         ovf;
    } exp_t;

    logic CLK, RESET;
    logic [127:0] p_a;
    logic in_valid_a, in_ready_a, flush_a, clear_a, sum_valid_a, sum_ready_a, overflow_a;
    logic [131:0] sum_a;
    logic [7:0] count_a;
    logic [15:0] p_b;
    logic in_valid_b, in_ready_b, flush_b, clear_b, sum_valid_b, sum_ready_b, overflow_b;
    logic [17:0] sum_b;
    logic [7:0] count_b;
    exp_t qa[$], qb[$];
    int vectors = 0, miscompares = 0;

    product_accumulator #(.bw(64), .GUARD(4), .NTERMS(4)) u_a (
        .CLK(CLK), .RESET(RESET), .P(p_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .flush(flush_a), .clear(clear_a), .SUM(sum_a), .sum_valid(sum_valid_a),
        .sum_ready(sum_ready_a), .count(count_a), .overflow(overflow_a));

    product_accumulator #(.bw(8), .GUARD(2), .NTERMS(8)) u_b (
        .CLK(CLK), .RESET(RESET), .P(p_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .flush(flush_b), .clear(clear_b), .SUM(sum_b), .sum_valid(sum_valid_b),
        .sum_ready(sum_ready_b), .count(count_b), .overflow(overflow_b));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // scoreboard: every completed handoff must match the oldest expected result
    always @(negedge CLK) begin
        if (!RESET && sum_valid_a && sum_ready_a) begin
            vectors++;
            if (qa.size() == 0) begin
                miscompares++;
                $display("FAIL a_unexpected_result got sum=%0d count=%0d ovf=%0b", sum_a, count_a, overflow_a);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if ({sum_a, count_a, overflow_a} !== {e.sum, e.cnt, e.ovf}) begin
                    miscompares++;
                    $display("FAIL a_result got sum=%0d count=%0d ovf=%0b want sum=%0d count=%0d ovf=%0b",
                             sum_a, count_a, overflow_a, e.sum, e.cnt, e.ovf);
                end
            end
        end
        if (!RESET && sum_valid_b && sum_ready_b) begin
            vectors++;
            if (qb.size() == 0) begin
                miscompares++;
                $display("FAIL b_unexpected_result got sum=%h count=%0d ovf=%0b", sum_b, count_b, overflow_b);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if ({sum_b, count_b, overflow_b} !== {e.sum[17:0], e.cnt, e.ovf}) begin
                    miscompares++;
                    $display("FAIL b_result got sum=%h count=%0d ovf=%0b want sum=%h count=%0d ovf=%0b",
                             sum_b, count_b, overflow_b, e.sum[17:0], e.cnt, e.ovf);
                end
            end
        end
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic put_a(input logic [127:0] v);
        p_a = v;
        in_valid_a = 1'b1;
        step();
    endtask

    task automatic put_b(input logic [15:0] v);
        p_b = v;
        in_valid_b = 1'b1;
        step();
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        #2;
        vectors++;
        if ({sum_a, sum_valid_a, count_a, overflow_a, in_ready_a} !== {132'd0, 1'b0, 8'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_a got sum=%0d sv=%b cnt=%0d ovf=%b ir=%b", sum_a, sum_valid_a, count_a, overflow_a, in_ready_a);
        end
        vectors++;
        if ({sum_b, sum_valid_b, count_b, overflow_b, in_ready_b} !== {18'd0, 1'b0, 8'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_b got sum=%0d sv=%b cnt=%0d ovf=%b ir=%b", sum_b, sum_valid_b, count_b, overflow_b, in_ready_b);
        end
        step();
        RESET = 1'b0;
    endtask

    task automatic test_basic;
        sum_ready_a = 1'b1;
        put_a(15); put_a(20); put_a(25);
        vectors++;
        if ({sum_valid_a, in_ready_a, count_a} !== {1'b0, 1'b1, 8'd3}) begin
            miscompares++;
            $display("FAIL basic_run got sv=%b ir=%b cnt=%0d want sv=0 ir=1 cnt=3", sum_valid_a, in_ready_a, count_a);
        end
        qa.push_back('{132'd90, 8'd4, 1'b0});
        put_a(30);
        in_valid_a = 1'b0;
        vectors++;
        if ({sum_valid_a, in_ready_a, count_a, overflow_a, sum_a} !== {1'b1, 1'b0, 8'd4, 1'b0, 132'd90}) begin
            miscompares++;
            $display("FAIL basic_hold got sv=%b ir=%b cnt=%0d ovf=%b sum=%0d want 1 0 4 0 90",
                     sum_valid_a, in_ready_a, count_a, overflow_a, sum_a);
        end
        step();
        vectors++;
        if ({sum_valid_a, in_ready_a, count_a} !== {1'b0, 1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL basic_release got sv=%b ir=%b cnt=%0d want 0 1 0", sum_valid_a, in_ready_a, count_a);
        end
    endtask

    task automatic test_backpressure;
        sum_ready_a = 1'b0;
        put_a(15); put_a(20); put_a(25);
        qa.push_back('{132'd90, 8'd4, 1'b0});
        put_a(30);
        p_a = 100;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({sum_valid_a, in_ready_a, count_a, sum_a} !== {1'b1, 1'b0, 8'd4, 132'd90}) begin
                miscompares++;
                $display("FAIL bp_hold%0d got sv=%b ir=%b cnt=%0d sum=%0d want 1 0 4 90", i, sum_valid_a, in_ready_a, count_a, sum_a);
            end
            step();
        end
        sum_ready_a = 1'b1;
        in_valid_a = 1'b0;
        step();
        vectors++;
        if ({sum_valid_a, in_ready_a, count_a} !== {1'b0, 1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL bp_release got sv=%b ir=%b cnt=%0d want 0 1 0", sum_valid_a, in_ready_a, count_a);
        end
        put_a(1); put_a(2); put_a(3);
        qa.push_back('{132'd10, 8'd4, 1'b0});
        put_a(4);
        in_valid_a = 1'b0;
        vectors++;
        if ({sum_valid_a, sum_a} !== {1'b1, 132'd10}) begin
            miscompares++;
            $display("FAIL bp_next_run got sv=%b sum=%0d want 1 10", sum_valid_a, sum_a);
        end
        step();
    endtask

    task automatic test_flush;
        put_a(7);
        flush_a = 1'b1;
        qa.push_back('{132'd16, 8'd2, 1'b0});
        put_a(9);
        flush_a = 1'b0;
        in_valid_a = 1'b0;
        vectors++;
        if ({sum_valid_a, count_a, sum_a} !== {1'b1, 8'd2, 132'd16}) begin
            miscompares++;
            $display("FAIL flush_two got sv=%b cnt=%0d sum=%0d want 1 2 16", sum_valid_a, count_a, sum_a);
        end
        step();
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        vectors++;
        if ({sum_valid_a, in_ready_a, count_a} !== {1'b0, 1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL flush_empty got sv=%b ir=%b cnt=%0d want 0 1 0", sum_valid_a, in_ready_a, count_a);
        end
        put_a(1); put_a(1); put_a(1);
        flush_a = 1'b1;
        qa.push_back('{132'd4, 8'd4, 1'b0});
        put_a(1);
        flush_a = 1'b0;
        in_valid_a = 1'b0;
        vectors++;
        if ({sum_valid_a, count_a} !== {1'b1, 8'd4}) begin
            miscompares++;
            $display("FAIL flush_at_nterms got sv=%b cnt=%0d want 1 4", sum_valid_a, count_a);
        end
        step();
        flush_a = 1'b1;
        qa.push_back('{132'd5, 8'd1, 1'b0});
        put_a(5);
        flush_a = 1'b0;
        in_valid_a = 1'b0;
        vectors++;
        if ({sum_valid_a, count_a, sum_a} !== {1'b1, 8'd1, 132'd5}) begin
            miscompares++;
            $display("FAIL flush_single got sv=%b cnt=%0d sum=%0d want 1 1 5", sum_valid_a, count_a, sum_a);
        end
        step();
    endtask

    task automatic test_overflow;
        sum_ready_b = 1'b1;
        repeat (4) put_b(16'hFFFF);
        vectors++;
        if (overflow_b !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_early got %b want 0", overflow_b);
        end
        repeat (3) put_b(16'hFFFF);
        vectors++;
        if (overflow_b !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_running got %b want 1", overflow_b);
        end
        qb.push_back('{132'h3FFF8, 8'd8, 1'b1});
        put_b(16'hFFFF);
        in_valid_b = 1'b0;
        vectors++;
        if ({sum_valid_b, count_b, overflow_b, sum_b} !== {1'b1, 8'd8, 1'b1, 18'h3FFF8}) begin
            miscompares++;
            $display("FAIL ovf_result got sv=%b cnt=%0d ovf=%b sum=%h want 1 8 1 3fff8", sum_valid_b, count_b, overflow_b, sum_b);
        end
        step();
        repeat (7) put_b(16'd1);
        qb.push_back('{132'd8, 8'd8, 1'b0});
        put_b(16'd1);
        in_valid_b = 1'b0;
        vectors++;
        if ({sum_valid_b, overflow_b, sum_b} !== {1'b1, 1'b0, 18'd8}) begin
            miscompares++;
            $display("FAIL ovf_next_run got sv=%b ovf=%b sum=%h want 1 0 8", sum_valid_b, overflow_b, sum_b);
        end
        step();
    endtask

    task automatic test_clear;
        put_a(5); put_a(5); put_a(5);
        clear_a = 1'b1;
        p_a = 50;
        step();
        clear_a = 1'b0;
        in_valid_a = 1'b0;
        vectors++;
        if ({sum_valid_a, in_ready_a, count_a, overflow_a, sum_a} !== {1'b0, 1'b1, 8'd0, 1'b0, 132'd5}) begin
            miscompares++;
            $display("FAIL clear_run got sv=%b ir=%b cnt=%0d ovf=%b sum=%0d want 0 1 0 0 5",
                     sum_valid_a, in_ready_a, count_a, overflow_a, sum_a);
        end
        put_a(1); put_a(1); put_a(1);
        qa.push_back('{132'd4, 8'd4, 1'b0});
        put_a(1);
        in_valid_a = 1'b0;
        vectors++;
        if ({sum_valid_a, count_a, sum_a} !== {1'b1, 8'd4, 132'd4}) begin
            miscompares++;
            $display("FAIL clear_next_run got sv=%b cnt=%0d sum=%0d want 1 4 4", sum_valid_a, count_a, sum_a);
        end
        step();
        sum_ready_a = 1'b0;
        repeat (4) put_a(2);
        in_valid_a = 1'b0;
        clear_a = 1'b1;
        step();
        clear_a = 1'b0;
        vectors++;
        if ({sum_valid_a, in_ready_a, count_a, sum_a} !== {1'b0, 1'b1, 8'd0, 132'd8}) begin
            miscompares++;
            $display("FAIL clear_hold got sv=%b ir=%b cnt=%0d sum=%0d want 0 1 0 8", sum_valid_a, in_ready_a, count_a, sum_a);
        end
        sum_ready_a = 1'b1;
    endtask

    task automatic test_async_reset;
        put_a(3); put_a(3);
        in_valid_a = 1'b0;
        #2 RESET = 1'b1;
        #1;
        vectors++;
        if ({count_a, sum_valid_a, in_ready_a, overflow_a, sum_a} !== {8'd0, 1'b0, 1'b1, 1'b0, 132'd0}) begin
            miscompares++;
            $display("FAIL areset_acc got cnt=%0d sv=%b ir=%b ovf=%b sum=%0d want 0 0 1 0 0",
                     count_a, sum_valid_a, in_ready_a, overflow_a, sum_a);
        end
        RESET = 1'b0;
        sum_ready_a = 1'b0;
        repeat (4) put_a(9);
        in_valid_a = 1'b0;
        #2 RESET = 1'b1;
        #1;
        vectors++;
        if ({sum_valid_a, in_ready_a, count_a, sum_a} !== {1'b0, 1'b1, 8'd0, 132'd0}) begin
            miscompares++;
            $display("FAIL areset_hold got sv=%b ir=%b cnt=%0d sum=%0d want 0 1 0 0", sum_valid_a, in_ready_a, count_a, sum_a);
        end
        RESET = 1'b0;
        sum_ready_a = 1'b1;
        put_a(10); put_a(20); put_a(30);
        qa.push_back('{132'd100, 8'd4, 1'b0});
        put_a(40);
        in_valid_a = 1'b0;
        vectors++;
        if ({sum_valid_a, count_a, sum_a} !== {1'b1, 8'd4, 132'd100}) begin
            miscompares++;
            $display("FAIL areset_next_run got sv=%b cnt=%0d sum=%0d want 1 4 100", sum_valid_a, count_a, sum_a);
        end
        step();
    endtask

    initial begin
        RESET = 1'b0;
        {p_a, in_valid_a, flush_a, clear_a, sum_ready_a} = '0;
        {p_b, in_valid_b, flush_b, clear_b, sum_ready_b} = '0;
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_overflow();
        test_clear();
        test_async_reset();
        step();
        vectors++;
        if (qa.size() != 0 || qb.size() != 0) begin
            miscompares++;
            $display("FAIL results_outstanding got a=%0d b=%0d want 0 0", qa.size(), qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
